// File: rtl/sram_byte_loader.sv
// -----------------------------------------------------------------------------
// sram_byte_loader
//
// Write-side packer for the 256 x 32-bit byte-masked activation/weight SRAM.
// A start/base/length command frames a transfer of raw 8-bit operands that
// arrive over a valid/ready stream. Every accepted byte becomes one
// single-lane SRAM write. Byte k of a transfer goes to word base + k/4, lane
// 3 - k%4, so the first byte of each word occupies bits [31:24].
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle command pulse, honoured only when idle
//   base_addr           first SRAM word of the transfer (sampled with start)
//   byte_count          number of bytes to load (sampled with start)
//   in_valid/in_data    byte stream input
//   in_ready            loader takes a byte this cycle (independent of in_valid)
//   busy                high from command acceptance through the done cycle
//   done                one-cycle completion pulse
//   err                 pulses with done when the command overran DEPTH
//   sram_csb/sram_wsb   SRAM chip/write enable, active low
//   sram_bytemask       lane select, one-hot for byte writes
//   sram_wdata          byte written to the selected lane
//   sram_waddr          target word address (holds its value between writes)
//
// Build option
//   LOADER_CLEAR_EN     when defined, every word of an accepted transfer is
//                       zeroed (bytemask 4'b0000) before loading starts, so
//                       unwritten lanes of a partial final word read as zero.
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_CHECK | one cycle: bounds check of base + ceil(count/4) against DEPTH
// ST_CLEAR | (LOADER_CLEAR_EN only) zero the target words, one per cycle
// ST_LOAD  | accept bytes and issue one single-lane write per byte
// ST_FIN   | one cycle: done (and err if rejected), then back to idle

module sram_byte_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [3:0]        sram_bytemask,
    output logic [7:0]        sram_wdata,
    output logic [ADDR_W-1:0] sram_waddr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
`ifdef LOADER_CLEAR_EN
        ST_CLEAR = 3'd2,
`endif
        ST_LOAD  = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // Wide enough that base + nwords cannot wrap for any legal input.
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [1:0]          lane_q, lane_d;
`ifdef LOADER_CLEAR_EN
    logic [LEN_W-1:0]    clr_cnt_q, clr_cnt_d;
`endif
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                csb_q, csb_d;
    logic                wsb_q, wsb_d;
    logic [3:0]          mask_q, mask_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;

    logic [LEN_W-1:0]    nwords;
    logic [SUM_W-1:0]    end_word;
    logic                overflow;
    logic                accept;

    // ceil(count/4) without the +3 carry that could wrap a near-full count.
    assign nwords   = (remaining_q >> 2) + {{(LEN_W-1){1'b0}}, |remaining_q[1:0]};
    assign end_word = SUM_W'(base_q) + SUM_W'(nwords);
    assign overflow = end_word > SUM_W'(DEPTH);
    assign accept   = in_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        lane_d      = lane_q;
`ifdef LOADER_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        ready_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        csb_d       = 1'b1;
        wsb_d       = 1'b1;
        mask_d      = 4'b0000;
        wdata_d     = 8'h00;
        waddr_d     = waddr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    remaining_d = byte_count;
                    busy_d      = 1'b1;
                    state_d     = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (overflow) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (remaining_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    word_d  = base_q;
                    lane_d  = 2'd0;
`ifdef LOADER_CLEAR_EN
                    clr_cnt_d = nwords;
                    state_d   = ST_CLEAR;
`else
                    state_d   = ST_LOAD;
`endif
                end
            end

`ifdef LOADER_CLEAR_EN
            ST_CLEAR: begin
                // Empty bytemask with an active write zeroes the whole word.
                csb_d     = 1'b0;
                wsb_d     = 1'b0;
                waddr_d   = word_q;
                clr_cnt_d = clr_cnt_q - LEN_W'(1);
                if (clr_cnt_q == LEN_W'(1)) begin
                    word_d  = base_q;
                    state_d = ST_LOAD;
                end else begin
                    word_d  = word_q + ADDR_W'(1);
                end
            end
`endif

            ST_LOAD: begin
                // in_ready is registered, so the first LOAD cycle never accepts.
                ready_d = (remaining_q != '0);
                if (accept) begin
                    csb_d       = 1'b0;
                    wsb_d       = 1'b0;
                    mask_d      = 4'b1000 >> lane_q;
                    wdata_d     = in_data;
                    waddr_d     = word_q;
                    remaining_d = remaining_q - LEN_W'(1);
                    lane_d      = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        word_d = word_q + ADDR_W'(1);
                    end
                    if (remaining_q == LEN_W'(1)) begin
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            lane_q      <= 2'd0;
`ifdef LOADER_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            csb_q       <= 1'b1;
            wsb_q       <= 1'b1;
            mask_q      <= 4'b0000;
            wdata_q     <= 8'h00;
            waddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
`ifdef LOADER_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            csb_q       <= csb_d;
            wsb_q       <= wsb_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
        end
    end

    assign in_ready      = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign sram_csb      = csb_q;
    assign sram_wsb      = wsb_q;
    assign sram_bytemask = mask_q;
    assign sram_wdata    = wdata_q;
    assign sram_waddr    = waddr_q;

endmodule

// File: tb/tb_sram_byte_loader.sv
// Directed bench for sram_byte_loader: a negedge monitor records SRAM writes
// into a behavioural byte-masked memory; a single initial block drives the
// commands and compares against hand-computed values.
module tb_sram_byte_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 256;
    localparam int LEN_W  = 11;
`ifdef LOADER_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  byte_count;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready, busy, done, err;
    logic              sram_csb, sram_wsb;
    logic [3:0]        sram_bytemask;
    logic [7:0]        sram_wdata;
    logic [ADDR_W-1:0] sram_waddr;

    sram_byte_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .byte_count(byte_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .err(err),
        .sram_csb(sram_csb), .sram_wsb(sram_wsb), .sram_bytemask(sram_bytemask),
        .sram_wdata(sram_wdata), .sram_waddr(sram_waddr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor (sole writer of its variables) ----------------
    logic [31:0] mem [0:1023];
    bit          init_done = 1'b0;
    int          done_cnt = 0, done_cyc = 0, ready_cnt = 0, bad_mask = 0, wr_n = 0;
    logic        done_err = 1'b0;
    logic [9:0]  wr_addr [0:2047];
    logic [3:0]  wr_mask [0:2047];
    logic [7:0]  wr_data [0:2047];
    int          wr_cyc  [0:2047];

    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hAAAAAAAA;
            init_done <= 1'b1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_err <= err;
        end
        if (in_ready) ready_cnt <= ready_cnt + 1;
        if (!sram_csb) begin
            if (wr_n < 2048) begin
                wr_addr[wr_n] <= sram_waddr;
                wr_mask[wr_n] <= sram_bytemask;
                wr_data[wr_n] <= sram_wdata;
                wr_cyc[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
            if (!sram_wsb) begin
                if (sram_bytemask == 4'b0000) mem[sram_waddr] <= 32'h0;
                if (sram_bytemask[3]) mem[sram_waddr][31:24] <= sram_wdata;
                if (sram_bytemask[2]) mem[sram_waddr][23:16] <= sram_wdata;
                if (sram_bytemask[1]) mem[sram_waddr][15:8]  <= sram_wdata;
                if (sram_bytemask[0]) mem[sram_waddr][7:0]   <= sram_wdata;
                if (sram_bytemask != 4'b0000 && !$onehot(sram_bytemask)) bad_mask <= bad_mask + 1;
`ifndef LOADER_CLEAR_EN
                if (sram_bytemask == 4'b0000) bad_mask <= bad_mask + 1;
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int         n_pass = 0, n_fail = 0, n_total = 0;
    int         tmo_cnt = 0, start_cyc = 0;
    logic [7:0] tx [0:1023];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
        base_addr  = b;
        byte_count = n;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic send(input int n, input bit toggle);
        for (int k = 0; k < n; k++) begin
            int w;
            bit ok;
            w  = 0;
            ok = 1'b0;
            in_valid = 1'b1;
            in_data  = tx[k];
            while (!ok && w < 64) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                w++;
            end
            if (!ok) tmo_cnt++;
            if (toggle) begin
                in_valid = 1'b0;
                in_data  = 8'h00;
                tick();
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int w;
        w = 0;
        while (done_cnt == d0 && w < budget) begin
            tick();
            w++;
        end
        if (done_cnt == d0) tmo_cnt++;
    endtask

    // Load writes recorded from index first must be byte k -> word base+k/4, lane 3-k%4.
    task automatic check_writes(input int first, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            logic [9:0] ea;
            logic [3:0] em;
            ea = 10'(base + k / 4);
            em = 4'b1000 >> (k % 4);
            check($sformatf("wr%0d", k), {10'h0, wr_addr[first+k], wr_mask[first+k], wr_data[first+k]},
                  {10'h0, ea, em, tx[k]});
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0, w0, r0;
        rst_n = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
        in_valid = 1'b0; in_data = 8'h00;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {4'h0, in_ready, busy, done, err, sram_csb, sram_wsb, sram_bytemask, sram_wdata, sram_waddr},
              {4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 10'h000});
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", {30'h0, busy, in_ready}, 32'h0);

        // T1: base 0, 8 bytes, in_valid held
        for (int k = 0; k < 8; k++) tx[k] = 8'(k + 1);
        d0 = done_cnt; w0 = wr_n;
        do_start(10'd0, 11'd8);
        send(8, 1'b0);
        wait_done(d0, 40);
        check("t1_latency", done_cyc - start_cyc, 11 + 2 * CLR);
        check("t1_err", {31'h0, done_err}, 32'h0);
        check("t1_nwrites", wr_n - w0, 8 + 2 * CLR);
        check_writes(w0 + 2 * CLR, 0, 8);
        for (int k = 1; k < 8; k++) check("t1_back2back", wr_cyc[w0+2*CLR+k] - wr_cyc[w0+2*CLR+k-1], 1);
        check("t1_word0", mem[0], 32'h01020304);
        check("t1_word1", mem[1], 32'h05060708);
        check("t1_busy_low", {31'h0, busy}, 32'h0);

        // T2: base 10, 6 bytes, in_valid toggling
        tx[0] = 8'h80; tx[1] = 8'h7F; tx[2] = 8'hFF; tx[3] = 8'h00; tx[4] = 8'hC3; tx[5] = 8'h5A;
        d0 = done_cnt; w0 = wr_n;
        do_start(10'd10, 11'd6);
        send(6, 1'b1);
        wait_done(d0, 60);
        check("t2_nwrites", wr_n - w0, 6 + 2 * CLR);
        check_writes(w0 + 2 * CLR, 10, 6);
        for (int k = 1; k < 6; k++) check("t2_bubble_gap", wr_cyc[w0+2*CLR+k] - wr_cyc[w0+2*CLR+k-1], 2);
        check("t2_word10", mem[10], 32'h807FFF00);
        check("t2_word11", mem[11], (CLR != 0) ? 32'hC35A0000 : 32'hC35AAAAA);

        // T3: base 255, 5 bytes -> rejected
        d0 = done_cnt; w0 = wr_n; r0 = ready_cnt;
        in_valid = 1'b1; in_data = 8'hEE;
        do_start(10'd255, 11'd5);
        wait_done(d0, 20);
        in_valid = 1'b0;
        check("t3_err", {31'h0, done_err}, 32'h1);
        check("t3_latency", done_cyc - start_cyc, 2);
        check("t3_no_sram", wr_n - w0, 0);
        check("t3_no_ready", ready_cnt - r0, 0);

        // T4: zero length, with a start pulsed while busy
        d0 = done_cnt; w0 = wr_n; r0 = ready_cnt;
        do_start(10'd3, 11'd0);
        base_addr = 10'd0; byte_count = 11'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("t4_one_done", done_cnt - d0, 1);
        check("t4_latency", done_cyc - start_cyc, 2);
        check("t4_err", {31'h0, done_err}, 32'h0);
        check("t4_no_sram", wr_n - w0, 0);
        check("t4_no_ready", ready_cnt - r0, 0);

        // T5: reset after the 3rd accepted byte of a 16-byte load
        for (int k = 0; k < 16; k++) tx[k] = 8'hD0 + 8'(k);
        d0 = done_cnt; w0 = wr_n;
        do_start(10'd20, 11'd16);
        send(3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_async_reset", {4'h0, in_ready, busy, done, err, sram_csb, sram_wsb, sram_bytemask, sram_wdata, sram_waddr},
              {4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 10'h000});
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_nwrites", wr_n - w0, 2 + 4 * CLR);
        check("t5_word20", mem[20], (CLR != 0) ? 32'hD0D10000 : 32'hD0D1AAAA);
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        d0 = done_cnt;
        do_start(10'd30, 11'd4);
        send(4, 1'b0);
        wait_done(d0, 30);
        check("t5_reload_latency", done_cyc - start_cyc, 7 + CLR);
        check("t5_reload_err", {31'h0, done_err}, 32'h0);
        check("t5_word30", mem[30], 32'h11223344);

`ifdef LOADER_CLEAR_EN
        // T6: clear sweep before a 9-byte load at base 4
        for (int k = 0; k < 9; k++) tx[k] = 8'h61 + 8'(k);
        d0 = done_cnt; w0 = wr_n;
        do_start(10'd4, 11'd9);
        send(9, 1'b0);
        wait_done(d0, 40);
        check("t6_nwrites", wr_n - w0, 12);
        for (int k = 0; k < 3; k++)
            check("t6_clear", {10'h0, wr_addr[w0+k], wr_mask[w0+k], wr_data[w0+k]},
                  {10'h0, 10'(4 + k), 4'b0000, 8'h00});
        check_writes(w0 + 3, 4, 9);
        check("t6_latency", done_cyc - start_cyc, 15);
        check("t6_word6", mem[6], 32'h69000000);
`endif

        // T7: full 1024-byte load, boundary base + nwords == DEPTH
        for (int k = 0; k < 1024; k++) tx[k] = 8'(k) ^ 8'h5C;
        d0 = done_cnt; w0 = wr_n;
        do_start(10'd0, 11'd1024);
        send(1024, 1'b0);
        wait_done(d0, 100);
        check("t7_latency", done_cyc - start_cyc, 1027 + 256 * CLR);
        check("t7_err", {31'h0, done_err}, 32'h0);
        check("t7_nwrites", wr_n - w0, 1024 + 256 * CLR);
        check("t7_last_write", {10'h0, wr_addr[wr_n-1], wr_mask[wr_n-1], wr_data[wr_n-1]},
              {10'h0, 10'd255, 4'b0001, 8'hA3});
        check("t7_word0", mem[0], 32'h5C5D5E5F);
        check("t7_word255", mem[255], 32'hA0A1A2A3);

        check("mask_onehot_violations", bad_mask, 0);
        check("handshake_timeouts", tmo_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_byte_loader.md
Name: sram_byte_loader

Overview:
- Upstream write-side stage for the 256-word x 32-bit byte-masked activation/weight SRAM in the matrix co-accelerator.
- Accepts a valid/ready stream of 8-bit operands and packs four consecutive bytes into one SRAM word, issuing one single-lane write per byte.
- A start/base/length command frames each transfer; done/err report completion to the controller.

Parameters:
- ADDR_W, 10, SRAM word-address width (matches SRAM waddr).
- DEPTH, 256, SRAM words physically present; bounds the overflow check.
- LEN_W, 11, byte-count width (max 4*DEPTH = 1024 bytes).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- byte_count  in  LEN_W  bytes to load; sampled with start.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte (signed int8 operand, treated as raw bits).
- in_ready  out  1  loader accepts a byte this cycle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, when the command was rejected.
- sram_csb  out  1  SRAM chip enable, active low.
- sram_wsb  out  1  SRAM write enable, active low.
- sram_bytemask  out  4  lane select; one-hot during LOAD writes.
- sram_wdata  out  8  byte written to the selected lane.
- sram_waddr  out  ADDR_W  target word address.

Behaviour:
- Reset values: in_ready=0, busy=0, done=0, err=0, sram_csb=1, sram_wsb=1, sram_bytemask=0, sram_wdata=0, sram_waddr=0. FSM goes to IDLE.
- FSM states: IDLE, CHECK, (CLEAR), LOAD, FIN.
- IDLE: start=1 latches base_addr and byte_count, sets busy, and moves to CHECK. start is ignored in every other state.
- CHECK (1 cycle):
  - nwords = ceil(byte_count/4).
  - If base_addr + nwords > DEPTH, go to FIN with err flagged; no SRAM access occurs.
  - Else if byte_count == 0, go to FIN with no error.
  - Otherwise go to LOAD (or CLEAR, see Optional Feature).
- LOAD:
  - in_ready=1 while remaining > 0.
  - Handshake: a byte is accepted when in_valid && in_ready. in_ready does not depend on in_valid.
  - Byte k of the transfer (k = 0..byte_count-1) goes to word base_addr + k/4, lane 3-(k%4). The first byte of each word lands in [31:24], bytemask 4'b1000; bytes then walk down to 4'b0001.
  - SRAM outputs are registered. The cycle after an accepted byte drives sram_csb=0, sram_wsb=0, the one-hot bytemask, sram_wdata=byte, and sram_waddr=word.
  - All other cycles drive sram_csb=1, sram_wsb=1, bytemask 0, and wdata 0; waddr holds its last value.
  - Bubbles on in_valid produce idle SRAM cycles. Byte order is preserved with no drops or duplicates.
  - When the last byte is accepted, in_ready drops in the next cycle and the state moves to FIN. The final write is on the SRAM port during that FIN cycle.
- FIN (1 cycle): done=1, err set as flagged, busy=0 on the following cycle, then return to IDLE.
- Bytemask 4'b0000 with an active write zeroes the whole SRAM word. LOAD must never emit a non-one-hot mask while sram_wsb=0.
- A partial final word (byte_count%4 != 0) writes only its lanes; the remaining lanes keep prior contents.
- No address wrap: the overflow check guarantees waddr never exceeds DEPTH-1. Example: base=255 with 5 bytes is rejected.
- Reset mid-transfer:
  - Immediately returns to IDLE with reset values.
  - Words already written stay written.
  - No done pulse is produced.
- Throughput: 1 byte/cycle; a full 1024-byte load takes 1027 cycles from start to done with in_valid held high.

Optional Feature:
- Macro LOADER_CLEAR_EN.
- Defined:
  - After a passing CHECK, the CLEAR state sweeps words base_addr..base_addr+nwords-1, one per cycle, with csb=0, wsb=0, bytemask=4'b0000, and wdata=0.
  - in_ready stays 0 during CLEAR; LOAD follows.
  - Unwritten lanes of the final word therefore read as zero.
  - Adds nwords cycles of latency. Zero-length and rejected commands skip CLEAR.
- Undefined: CLEAR state and its logic are absent; CHECK goes directly to LOAD.

Test Plan:
- Reset, then start base=0, count=8, bytes 0x01..0x08 with in_valid held → writes to word0 lanes 3..0 = 01,02,03,04 and word1 = 05..08; word0 reads 0x01020304, word1 reads 0x05060708; done 11 cycles after start.
- base=10, count=6, in_valid toggling 1/0 → six one-hot writes with idle SRAM cycles in the bubbles; word10=byte0..3, word11[31:16]=byte4..5; word11[15:0] unchanged from preload 0xAAAA (or 0x0000 with LOADER_CLEAR_EN).
- base=255, count=5 → err=1 with done; no cycle with sram_csb=0; in_ready never 1.
- count=0 → done pulse 2 cycles after start, err=0, no SRAM activity; a start pulsed while busy is ignored.
- Deassert rst_n after the 3rd accepted byte of a 16-byte load → outputs return to reset values asynchronously, no done pulse; a new 4-byte load afterwards completes normally.
- LOADER_CLEAR_EN, base=4, count=9 → three bytemask=0000 writes to words 4,5,6, then 9 one-hot writes; word6 reads byte8<<24.
